// File: rtl/rom_arbiter_if.sv
// Requester/ROM bus of the dual-port ROM arbiter.
// slave is the arbiter side; master is the requester/ROM side.
interface rom_arbiter_if #(
  parameter int data_width = 8,
  parameter int addr_width = 8,
  parameter int n_req      = 4
);
  logic [n_req-1:0]            req;
  logic [n_req*addr_width-1:0] req_addr;
  logic [n_req-1:0]            gnt;
  logic [n_req-1:0]            rsp_valid;
  logic [n_req*data_width-1:0] rsp_data;
  logic [addr_width-1:0]       rom_addr_a;
  logic [addr_width-1:0]       rom_addr_b;
  logic [data_width-1:0]       rom_q_a;
  logic [data_width-1:0]       rom_q_b;

  modport slave (
    input  req, req_addr, rom_q_a, rom_q_b,
    output gnt, rsp_valid, rsp_data, rom_addr_a, rom_addr_b
  );

  modport master (
    output req, req_addr, rom_q_a, rom_q_b,
    input  gnt, rsp_valid, rsp_data, rom_addr_a, rom_addr_b
  );
endinterface

// File: rtl/rom_arbiter.sv
// Round-robin arbiter sharing a dual-port synchronous ROM among n_req requesters.
// Up to two grants per cycle; each response returns exactly two cycles after its grant.
module rom_arbiter #(
  parameter int data_width = 8,
  parameter int addr_width = 8,
  parameter int n_req      = 4
) (
  input logic           clk,
  input logic           rst_n,
  rom_arbiter_if.slave  bus
);
  localparam int PW = (n_req > 2) ? $clog2(n_req) : 1;

  logic [PW-1:0]               rr_ptr;
  logic [PW-1:0]               rr_ptr_nxt;
  logic [PW-1:0]               last_idx;
  logic                        a_hit, b_hit;
  logic [PW-1:0]               a_idx, b_idx;
  logic [n_req-1:0]            gnt_c;
  int                          scan_idx;

  logic                        s1_vld_a, s1_vld_b;
  logic [PW-1:0]               s1_own_a, s1_own_b;
  logic [n_req-1:0]            rsp_valid_q;
  logic [n_req*data_width-1:0] rsp_data_q;

  // Circular scan from rr_ptr: first hit goes to port A, second to port B.
  always_comb begin
    a_hit    = 1'b0;
    b_hit    = 1'b0;
    a_idx    = '0;
    b_idx    = '0;
    scan_idx = 0;
    for (int k = 0; k < n_req; k++) begin
      scan_idx = (int'(rr_ptr) + k) % n_req;
      if (bus.req[scan_idx]) begin
        if (!a_hit) begin
          a_hit = 1'b1;
          a_idx = PW'(scan_idx);
        end else if (!b_hit) begin
          b_hit = 1'b1;
          b_idx = PW'(scan_idx);
        end
      end
    end
  end

  always_comb begin
    gnt_c = '0;
    if (a_hit) gnt_c[a_idx] = 1'b1;
    if (b_hit) gnt_c[b_idx] = 1'b1;
  end

  assign bus.gnt = rst_n ? gnt_c : '0;

  always_comb begin
    bus.rom_addr_a = '0;
    bus.rom_addr_b = '0;
    if (a_hit) bus.rom_addr_a = bus.req_addr[int'(a_idx)*addr_width +: addr_width];
    if (b_hit) bus.rom_addr_b = bus.req_addr[int'(b_idx)*addr_width +: addr_width];
  end

  always_comb begin
    last_idx   = b_hit ? b_idx : a_idx;
    rr_ptr_nxt = (last_idx == PW'(n_req - 1)) ? '0 : last_idx + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (a_hit) begin
      rr_ptr <= rr_ptr_nxt;
    end
  end

  // Stage 1: remember which requester owns each ROM port while the ROM reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_a <= 1'b0;
      s1_vld_b <= 1'b0;
      s1_own_a <= '0;
      s1_own_b <= '0;
    end else begin
      s1_vld_a <= a_hit;
      s1_vld_b <= b_hit;
      s1_own_a <= a_idx;
      s1_own_b <= b_idx;
    end
  end

  // Stage 2: route ROM data to its owner's slice; unowned slices keep their value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= '0;
      if (s1_vld_a) begin
        rsp_valid_q[s1_own_a]                                <= 1'b1;
        rsp_data_q[int'(s1_own_a)*data_width +: data_width]  <= bus.rom_q_a;
      end
      if (s1_vld_b) begin
        rsp_valid_q[s1_own_b]                                <= 1'b1;
        rsp_data_q[int'(s1_own_b)*data_width +: data_width]  <= bus.rom_q_b;
      end
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
endmodule

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 SHALL have parameter data_width, default 8, ROM word width in bits.
REQ-002 SHALL have parameter addr_width, default 8, ROM address width in bits.
REQ-003 SHALL have parameter n_req, default 4, number of requesters, legal range 2..8.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port req  input  n_req  per-requester read request, held until granted.
REQ-007 SHALL have port req_addr  input  n_req*addr_width  per-requester address; requester i uses slice [i*addr_width +: addr_width].
REQ-008 SHALL have port gnt  output  n_req  combinational one-hot-per-port grant, same cycle as req.
REQ-009 SHALL have port rsp_valid  output  n_req  registered one-cycle response strobe per requester.
REQ-010 SHALL have port rsp_data  output  n_req*data_width  registered response data, slice i belongs to requester i.
REQ-011 SHALL have ports rom_addr_a, rom_addr_b  output  addr_width  address to ROM ports A and B.
REQ-012 SHALL have ports rom_q_a, rom_q_b  input  data_width  ROM read data, valid one cycle after address.

Function
REQ-013 SHALL grant at most two requesters per cycle: first requester at or after rr_ptr (circular scan) to port A, next requester after that to port B.
REQ-014 SHALL drive rom_addr_a/rom_addr_b with the granted requester's req_addr in the grant cycle; an unused port SHALL drive address 0.
REQ-015 SHALL update rr_ptr to (index of last granted requester + 1) mod n_req when any grant occurs; no grant -> rr_ptr unchanged.
REQ-016 SHALL set gnt[i] only when req[i] is high; gnt SHALL be all-zero while rst_n is low.
REQ-017 SHALL register per-port owner index and valid bit (stage 1) at the grant-cycle edge.
REQ-018 SHALL, one cycle later (stage 2), capture rom_q_a/rom_q_b into the owner's rsp_data slice and pulse that owner's rsp_valid.
REQ-019 SHALL have fixed latency: grant in cycle T -> rsp_valid high exactly in cycle T+2, for exactly one cycle per grant.
REQ-020 SHALL sustain full throughput: two grants per cycle, back-to-back, with no bubbles.
REQ-021 SHALL hold each rsp_data slice at its last captured value when rsp_valid is low.
REQ-022 SHALL treat a requester held high after grant as a new request; it is eligible again the next cycle under round-robin.
REQ-023 SHALL serve two requesters presenting the same address independently, each receiving its own response.
REQ-024 SHALL guarantee starvation freedom: a continuously requesting requester is granted within ceil(n_req/2) cycles.

Reset
REQ-025 SHALL on rst_n low asynchronously clear rr_ptr to 0, stage-1 and stage-2 valid bits to 0, rsp_valid to 0, rsp_data to 0.
REQ-026 SHALL discard in-flight reads when reset asserts mid-operation; no rsp_valid SHALL appear for them after release.
REQ-027 SHALL accept requests in the first clock cycle after rst_n deasserts.

Verification
REQ-028 SHALL cover: after reset, req=4'b0001, addr0=8'h05 -> gnt=4'b0001 same cycle, rom_addr_a=8'h05, rsp_valid[0] at T+2 with rsp_data[0]=rom[5].
REQ-029 SHALL cover: req=4'b1111 held 4 cycles, rr_ptr=0 -> grants {0,1},{2,3},{0,1},{2,3}; 8 responses, each at grant+2.
REQ-030 SHALL cover: req=4'b1001, rr_ptr=2 -> port A=requester 3, port B=requester 0, rr_ptr becomes 1.
REQ-031 SHALL cover: requesters 1 and 2 both addr 8'hFF -> both rsp_valid in same cycle, both data=rom[255].
REQ-032 SHALL cover: grant in cycle T, rst_n pulsed low in T+1 -> no rsp_valid in T+2, all outputs zero, rr_ptr=0.
REQ-033 SHALL cover: random req/addr for 10000 cycles against a reference model -> every grant yields exactly one correct response, no requester waits more than 2 cycles.
